max_pool_controller: RTL

Streaming sequencer for a 2x2, stride-2 max-pooling stage. Accepts an IMG_W x IMG_H feature map one pixel per handshake in row-major order, holds even rows in an internal line buffer, and on each odd-row/odd-column pixel assembles a four-value window. The window feeds an internal `max_pooling_unit` (SIZE=4). The pooled result is presented on a registered valid/ready output. It sits between a convolution layer output stream and the next layer input.

---
 rtl/max_pool_controller.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/max_pool_controller.sv
// 2x2 stride-2 max-pooling sequencer: buffers even rows, forms windows on odd-row/odd-col
// pixels and presents pooled results on a registered valid/ready output.

module max_pooling_unit #(
  parameter int SIZE    = 4,
  parameter int D_WIDTH = 8
) (
  input  logic [SIZE*D_WIDTH-1:0] in_vec,
  output logic [D_WIDTH-1:0]      max_val
);

  // Unsigned running maximum across all lanes, lane 0 first.
  always_comb begin
    max_val = in_vec[D_WIDTH-1:0];
    for (int i = 1; i < SIZE; i++) begin
      if (in_vec[i*D_WIDTH +: D_WIDTH] > max_val) begin
        max_val = in_vec[i*D_WIDTH +: D_WIDTH];
      end else begin
        max_val = max_val;
      end
    end
  end

endmodule

module max_pool_controller #(
  parameter int D_WIDTH = 8,
  parameter int IMG_W   = 8,
  parameter int IMG_H   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [D_WIDTH-1:0] in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [D_WIDTH-1:0] out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               done
);

  localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_EVEN_ROW = 2'd1,
    S_ODD_ROW  = 2'd2,
    S_DRAIN    = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      col_q, col_d;
  logic [RW-1:0]      row_q, row_d;
  logic [D_WIDTH-1:0] line_buf_q [IMG_W];
  logic [D_WIDTH-1:0] line_buf_d [IMG_W];
  logic [D_WIDTH-1:0] left_q, left_d;
  logic [D_WIDTH-1:0] out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic               done_q, done_d;

  logic               in_ready_s;
  logic               in_hs_s;
  logic               out_hs_s;
  logic [CW-1:0]      col_prev_s;
  logic [4*D_WIDTH-1:0] window_s;
  logic [D_WIDTH-1:0] pool_max_s;

  // The odd-col window pixel may only enter when the output slot is free or draining now.
  always_comb begin
    case (state_q)
      S_EVEN_ROW: in_ready_s = 1'b1;
      S_ODD_ROW:  in_ready_s = col_q[0] ? (!out_valid_q || out_ready) : 1'b1;
      default:    in_ready_s = 1'b0;
    endcase
  end

  assign in_hs_s    = in_valid && in_ready_s;
  assign out_hs_s   = out_valid_q && out_ready;
  assign col_prev_s = col_q - CW'(1);
  assign window_s   = {in_data, left_q, line_buf_q[col_q], line_buf_q[col_prev_s]};

  max_pooling_unit #(
    .SIZE    (4),
    .D_WIDTH (D_WIDTH)
  ) u_max (
    .in_vec  (window_s),
    .max_val (pool_max_s)
  );

  // Next-state, counter, buffer and output-register logic.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    line_buf_d  = line_buf_q;
    left_d      = left_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;

    if (out_hs_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_EVEN_ROW;
          col_d   = {CW{1'b0}};
          row_d   = {RW{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EVEN_ROW: begin
        if (in_hs_s) begin
          line_buf_d[col_q] = in_data;
          if (col_q == COL_LAST) begin
            col_d   = {CW{1'b0}};
            row_d   = row_q + RW'(1);
            state_d = S_ODD_ROW;
          end else begin
            col_d = col_q + CW'(1);
          end
        end else begin
          state_d = S_EVEN_ROW;
        end
      end
      S_ODD_ROW: begin
        if (in_hs_s) begin
          if (col_q[0]) begin
            out_data_d  = pool_max_s;
            out_valid_d = 1'b1;
          end else begin
            left_d = in_data;
          end
          if (col_q == COL_LAST) begin
            col_d = {CW{1'b0}};
            if (row_q == ROW_LAST) begin
              row_d   = {RW{1'b0}};
              state_d = S_DRAIN;
            end else begin
              row_d   = row_q + RW'(1);
              state_d = S_EVEN_ROW;
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end else begin
          state_d = S_ODD_ROW;
        end
      end
      S_DRAIN: begin
        if (out_hs_s) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      col_q       <= {CW{1'b0}};
      row_q       <= {RW{1'b0}};
      left_q      <= {D_WIDTH{1'b0}};
      out_data_q  <= {D_WIDTH{1'b0}};
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      left_q      <= left_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  // Line buffer holds pixel data only; its contents are irrelevant after reset.
  always_ff @(posedge clk) begin
    line_buf_q <= line_buf_d;
  end

  assign in_ready  = in_ready_s;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;

endmodule
